// File: rtl/ysyx_25010008_sram_slave.sv
// ysyx_25010008_sram_slave
// AXI4-Lite-style memory responder for the LSU load/store bus. Owns a
// word-addressed storage array and serves independent read and write
// channels with programmable latency, byte strobes and error responses.
//
// Parameters:
//   BASE_ADDR    first byte address decoded by this block
//   DEPTH_WORDS  storage size in 32-bit words (power of two, >= 4)
//   READ_LAT     wait cycles between AR handshake and rvalid (0..15)
//   WRITE_LAT    wait cycles between AW+W collection and bvalid (0..15)
//
// Ports:
//   clock, reset              rising-edge clock, async active-low reset
//   araddr/arsize/arvalid/arready        read address channel
//   rdata/rresp/rvalid/rready            read data channel (full word)
//   awaddr/awsize/awvalid/awready        write address channel
//   wdata/wstrb/wvalid/wready            write data channel
//   bresp/bvalid/bready                  write response channel
//   resp encoding: 0 OKAY, 2 SLVERR, 3 DECERR
//
// Build option:
//   YSYX_SRAM_RAND_DELAY_EN  when defined, an 8-bit LFSR adds 0..3 cycles to
//                            every latency counter load.
module ysyx_25010008_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned WRITE_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W     = 5;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    r_state_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      rd_addr;
    logic [2:0]       rd_size;

    w_state_t         w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [31:0]      wr_addr;
    logic [2:0]       wr_size;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic             aw_held;
    logic             w_held;

    logic [CNT_W-1:0] r_load_c;
    logic [CNT_W-1:0] w_load_c;

    // Latency counter load values, optionally jittered by the LFSR.
`ifdef YSYX_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; free-running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign r_load_c = CNT_W'(READ_LAT) + CNT_W'(lfsr[1:0]);
    assign w_load_c = CNT_W'(WRITE_LAT) + CNT_W'(lfsr[1:0]);
`else
    assign r_load_c = CNT_W'(READ_LAT);
    assign w_load_c = CNT_W'(WRITE_LAT);
`endif

    // Address decode and error classification for the latched read request.
    logic [31:0]      rd_off_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic [1:0]       rd_resp_c;

    assign rd_off_c = rd_addr - BASE_ADDR;
    assign rd_idx_c = rd_off_c[IDX_W+1:2];

    always_comb begin
        rd_resp_c = RESP_OKAY;
        if (rd_off_c >= MEM_BYTES) begin
            rd_resp_c = RESP_DECERR;
        end else if ((rd_size > 3'd2) ||
                     ((rd_size == 3'd1) && rd_addr[0]) ||
                     ((rd_size == 3'd2) && (rd_addr[1:0] != 2'b00))) begin
            rd_resp_c = RESP_SLVERR;
        end
    end

    // Address decode and error classification for the latched write request.
    logic [31:0]      wr_off_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic [1:0]       wr_resp_c;

    assign wr_off_c = wr_addr - BASE_ADDR;
    assign wr_idx_c = wr_off_c[IDX_W+1:2];

    always_comb begin
        wr_resp_c = RESP_OKAY;
        if (wr_off_c >= MEM_BYTES) begin
            wr_resp_c = RESP_DECERR;
        end else if ((wr_size > 3'd2) ||
                     ((wr_size == 3'd1) && wr_addr[0]) ||
                     ((wr_size == 3'd2) && (wr_addr[1:0] != 2'b00))) begin
            wr_resp_c = RESP_SLVERR;
        end
    end

    // Read channel FSM. R_RESP is entered with rvalid low; the following
    // edge samples the array and raises rvalid, so a write committed one
    // edge earlier is already visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            rd_addr <= '0;
            rd_size <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rd_addr <= araddr;
                        rd_size <= arsize;
                        r_cnt   <= r_load_c;
                        arready <= 1'b0;
                        r_state <= (r_load_c == '0) ? R_RESP : R_WAIT;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (!rvalid) begin
                        rvalid <= 1'b1;
                        rresp  <= rd_resp_c;
                        rdata  <= (rd_resp_c == RESP_OKAY) ? mem[rd_idx_c] : 32'h0;
                    end else if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // Write channel FSM. AW and W are latched independently in W_COLLECT;
    // the counter starts on the edge that completes the pair.
    logic aw_fire_c;
    logic w_fire_c;
    logic aw_have_c;
    logic w_have_c;

    assign aw_fire_c = awvalid && awready;
    assign w_fire_c  = wvalid && wready;
    assign aw_have_c = aw_held || aw_fire_c;
    assign w_have_c  = w_held || w_fire_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state <= W_COLLECT;
            w_cnt   <= '0;
            wr_addr <= '0;
            wr_size <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= '0;
        end else begin
            case (w_state)
                W_COLLECT: begin
                    if (aw_fire_c) begin
                        wr_addr <= awaddr;
                        wr_size <= awsize;
                        aw_held <= 1'b1;
                    end
                    if (w_fire_c) begin
                        wr_data <= wdata;
                        wr_strb <= wstrb;
                        w_held  <= 1'b1;
                    end
                    if (aw_have_c && w_have_c) begin
                        w_cnt   <= w_load_c;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        w_state <= (w_load_c == '0) ? W_RESP : W_WAIT;
                    end else begin
                        awready <= !aw_have_c;
                        wready  <= !w_have_c;
                    end
                end
                W_WAIT: begin
                    w_cnt <= w_cnt - CNT_W'(1);
                    if (w_cnt <= CNT_W'(1)) begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (!bvalid) begin
                        bvalid <= 1'b1;
                        bresp  <= wr_resp_c;
                    end else if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_COLLECT;
                    end
                end
                default: begin
                    w_state <= W_COLLECT;
                end
            endcase
        end
    end

    // Commit happens on the edge that raises bvalid; errors never touch the array.
    logic mem_we_c;

    assign mem_we_c = (w_state == W_RESP) && !bvalid && (wr_resp_c == RESP_OKAY);

    // Storage array has no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx_c][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_sram_slave.sv
module tb_ysyx_25010008_sram_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int RLAT = 1;
    localparam int WLAT = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arsize = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awsize = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ysyx_25010008_sram_slave #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(1024),
        .READ_LAT   (RLAT),
        .WRITE_LAT  (WLAT)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .araddr (araddr),
        .arsize (arsize),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .awaddr (awaddr),
        .awsize (awsize),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int lat, input int base);
`ifdef YSYX_SRAM_RAND_DELAY_EN
        total++;
        assert (lat >= base + 1 && lat <= base + 4) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, lat, base + 1, base + 4);
        end
`else
        chk(tag, 32'(lat), 32'(base + 1));
`endif
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Full write transaction with bready held high; lat counts edges after the AW/W edge.
    task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output int lat);
        int n;
        @(negedge clock);
        awaddr = addr; awsize = size; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) timeout("write_accept");
        @(posedge clock);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!bvalid) timeout("bvalid_wait");
        resp = bresp;
    endtask

    // Full read transaction with rready held high; lat counts edges after the AR edge.
    task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        @(negedge clock);
        araddr = addr; arsize = size; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) timeout("read_accept");
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!rvalid) timeout("rvalid_wait");
        data = rdata;
        resp = rresp;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
        int          n;
        logic [31:0] model [16];
        logic [31:0] rnd;
        logic [3:0]  strb;
        int          idx;

        // Reset values while reset is held low.
        #12;
        chk("reset_ready_valid", 32'({arready, rvalid, awready, wready, bvalid}), 32'h0);
        chk("reset_resp", 32'({rresp, bresp}), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_ready", 32'({arready, awready, wready}), 32'h7);

        // Word write then read back.
        do_write(BASE + 32'h10, 3'd2, 32'hDEAD_BEEF, 4'hF, resp, lat);
        chk("wr_word_bresp", 32'(resp), 32'h0);
        chk_lat("wr_word_lat", lat, WLAT);
        do_read(BASE + 32'h10, 3'd2, data, resp, lat);
        chk("rd_word_data", data, 32'hDEAD_BEEF);
        chk("rd_word_rresp", 32'(resp), 32'h0);
        chk_lat("rd_word_lat", lat, RLAT);

        // Byte strobe merge.
        do_write(BASE + 32'h10, 3'd2, 32'h1122_3344, 4'hF, resp, lat);
        do_write(BASE + 32'h12, 3'd0, 32'h00AB_0000, 4'b0100, resp, lat);
        chk("wr_byte_bresp", 32'(resp), 32'h0);
        do_read(BASE + 32'h10, 3'd2, data, resp, lat);
        chk("rd_byte_merge", data, 32'h11AB_3344);

        // Aligned halfword write into the upper half.
        do_write(BASE + 32'h14, 3'd2, 32'h0102_0304, 4'hF, resp, lat);
        do_write(BASE + 32'h16, 3'd1, 32'hBEEF_0000, 4'b1100, resp, lat);
        chk("wr_half_bresp", 32'(resp), 32'h0);
        do_read(BASE + 32'h14, 3'd2, data, resp, lat);
        chk("rd_half_merge", data, 32'hBEEF_0304);

        // Decode errors.
        do_read(BASE + 32'h1000, 3'd2, data, resp, lat);
        chk("rd_oor_rresp", 32'(resp), 32'h3);
        chk("rd_oor_rdata", data, 32'h0);
        do_read(32'h7FFF_FFFC, 3'd2, data, resp, lat);
        chk("rd_below_rresp", 32'(resp), 32'h3);

        // Alignment and size errors; memory must stay untouched.
        do_write(BASE, 3'd2, 32'hCAFE_F00D, 4'hF, resp, lat);
        do_write(BASE + 32'h2, 3'd2, 32'h1234_5678, 4'hF, resp, lat);
        chk("wr_misalign_bresp", 32'(resp), 32'h2);
        do_write(BASE + 32'h1, 3'd1, 32'h5555_5555, 4'hF, resp, lat);
        chk("wr_half_odd_bresp", 32'(resp), 32'h2);
        do_write(BASE, 3'd3, 32'h6666_6666, 4'hF, resp, lat);
        chk("wr_size3_bresp", 32'(resp), 32'h2);
        do_write(BASE + 32'h1000, 3'd2, 32'h7777_7777, 4'hF, resp, lat);
        chk("wr_oor_bresp", 32'(resp), 32'h3);
        do_read(BASE, 3'd2, data, resp, lat);
        chk("mem_unchanged", data, 32'hCAFE_F00D);
        do_read(BASE + 32'h11, 3'd1, data, resp, lat);
        chk("rd_half_odd_rresp", 32'(resp), 32'h2);
        chk("rd_err_rdata", data, 32'h0);

        // Last word of the array.
        do_write(BASE + 32'hFFC, 3'd2, 32'hA5A5_5A5A, 4'hF, resp, lat);
        chk("wr_last_bresp", 32'(resp), 32'h0);
        do_read(BASE + 32'hFFC, 3'd2, data, resp, lat);
        chk("rd_last_data", data, 32'hA5A5_5A5A);

        // W two cycles ahead of AW, then bready held low for 5 cycles.
        @(negedge clock);
        bready = 1'b0;
        wdata = 32'h5A5A_1234; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wvalid = 1'b0;
        chk("w_first_ready", 32'({awready, wready}), 32'h2);
        @(negedge clock);
        awaddr = BASE + 32'h20; awsize = 3'd2; awvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        awvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!bvalid) timeout("bvalid_order");
        chk_lat("w_first_lat", lat, WLAT);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (bvalid === 1'b1 && bresp === 2'd0) n++;
        end
        chk("bp_hold_cycles", 32'(n), 32'd5);
        bready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_release", 32'(bvalid), 32'h0);
        do_read(BASE + 32'h20, 3'd2, data, resp, lat);
        chk("w_first_data", data, 32'h5A5A_1234);

        // Reset asserted while the read sits in R_WAIT.
        @(negedge clock);
        araddr = BASE + 32'h14; arsize = 3'd2; arvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        arvalid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({arready, rvalid, awready, wready, bvalid}), 32'h0);
        chk("rst_mid_resp", 32'({rresp, bresp}), 32'h0);
        chk("rst_mid_rdata", rdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_release", 32'({arready, rvalid}), 32'h2);
        do_read(BASE + 32'h10, 3'd2, data, resp, lat);
        chk("rst_data_kept", data, 32'h11AB_3344);

        // Random word traffic against a small reference model.
        for (int i = 0; i < 16; i++) begin
            rnd = $urandom;
            do_write(BASE + 32'(4 * i), 3'd2, rnd, 4'hF, resp, lat);
            model[i] = rnd;
            chk("rnd_init_bresp", 32'(resp), 32'h0);
        end
        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                rnd  = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(BASE + 32'(4 * idx), 3'd2, rnd, strb, resp, lat);
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model[idx][8*b +: 8] = rnd[8*b +: 8];
                end
                chk("rnd_bresp", 32'(resp), 32'h0);
                chk_lat("rnd_wlat", lat, WLAT);
            end else begin
                do_read(BASE + 32'(4 * idx), 3'd2, data, resp, lat);
                chk("rnd_rdata", data, model[idx]);
                chk_lat("rnd_rlat", lat, RLAT);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
